rom_read_sequencer: RTL and testbench
=====================================

Name: rom_read_sequencer

Overview:
Sequences a full read-out of a 556PT5 (3604) or 556PT4 (3601) PROM. It walks the address bus from 0 to a programmable last address and drives the chip operation lines. For each address it waits a fixed access time, then captures the chip data. Each captured word is presented to a downstream consumer (UART/host packer) over a valid/ready handshake. It sits between the top-level start/abort controls and the PROM socket pins, and replaces manual address stepping for bulk dumps.

Parameters:
DATA_WIDTH, 8, chip data width (8 for 3604, 4 for 3601)
ADDRESS_WIDTH, 9, chip address width (9 for 3604, 8 for 3601)
ACCESS_CYCLES, 4, clk cycles the address/operation are held before data capture; legal range 1..255
READ_OP, 4'b1100, value driven on operation while reading (bit0=V1 .. bit3=V4)
IDLE_OP, 4'b0000, value driven on operation when not reading

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  level; sampled only in IDLE, begins a dump
abort  input  1  level; terminates a dump from any non-IDLE state
last_address  input  ADDRESS_WIDTH  final address of the dump, sampled on the start edge
operation  output  4  chip operation lines V1..V4
address_line  output  ADDRESS_WIDTH  chip address bus
data_line_in  input  DATA_WIDTH  chip data bus
out_data  output  DATA_WIDTH  captured word
out_addr  output  ADDRESS_WIDTH  address of out_data
out_valid  output  1  out_data/out_addr valid
out_ready  input  1  consumer accepts the word
busy  output  1  dump in progress
done  output  1  one-cycle pulse at normal completion

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, operation=IDLE_OP, address_line=0, out_data=0, out_addr=0, out_valid=0, busy=0, done=0, wait counter=0, latched last address=0.
- States: IDLE, SETUP, OUTPUT, DONE. All outputs are registered.
- IDLE:
  - If start=1 at an edge: latch last_address, address_line=0, operation=READ_OP, busy=1, wait counter=ACCESS_CYCLES-1, go to SETUP.
  - Otherwise hold. start is ignored in every other state.
- SETUP:
  - address_line and operation are held stable.
  - If the counter is nonzero, decrement it.
  - If the counter is zero, at that edge capture out_data<=data_line_in and out_addr<=address_line, set out_valid=1, go to OUTPUT.
  - Result: exactly ACCESS_CYCLES cycles in SETUP per address. The first capture occurs ACCESS_CYCLES edges after the start edge.
- OUTPUT:
  - out_valid stays 1; out_data/out_addr stay stable until an edge with out_ready=1.
  - On the handshake edge, out_valid<=0.
  - If address_line==latched last address: go to DONE with done=1, operation=IDLE_OP.
  - Otherwise: address_line+1, counter=ACCESS_CYCLES-1, go to SETUP.
  - With out_ready held high, throughput is one word per ACCESS_CYCLES+1 cycles.
- DONE: lasts exactly one cycle. done=1, busy=1 during it. Next edge: done=0, busy=0, go to IDLE. address_line retains the last address.
- End-of-range comparison is made before incrementing. last_address = 2^ADDRESS_WIDTH-1 therefore never wraps the counter. last_address=0 produces exactly one word.
- abort=1 in SETUP, OUTPUT or DONE: next edge go to IDLE, out_valid=0, busy=0, done=0, operation=IDLE_OP, address_line=0. A pending word is discarded and done is never pulsed. abort has priority over the handshake and the end-of-range check.
- abort and start both high in IDLE: start is ignored.
- Reset asserted mid-dump: immediate return to the reset values; no done pulse.

Test Plan:
- Full 3604 dump: last_address=511, ACCESS_CYCLES=4, out_ready=1, chip model data=addr[7:0]^8'hA5. Expect 512 words with out_addr 0..511, correct data, done pulse once, 2560 cycles from start edge to done edge.
- Backpressure: out_ready low for 7 cycles on word 3. Expect out_valid held with out_data/out_addr constant and address_line=3 unchanged. Expect no skipped or duplicated words.
- Single word: last_address=0. Expect exactly one word (addr 0), then done, then busy=0 and operation=IDLE_OP.
- Abort: raise abort while in OUTPUT at word 10. Expect next cycle out_valid=0, busy=0, operation=4'b0000, address_line=0, and no done pulse. A following start restarts at address 0.
- Async reset: pull reset_n low between clock edges mid-SETUP. Expect all outputs at reset values before the next edge. start during busy is verified to have no effect.
- 3601 configuration (DATA_WIDTH=4, ADDRESS_WIDTH=8, ACCESS_CYCLES=1, last_address=255). Expect 256 words at 2 cycles each and no address overflow.

Source files
------------

// File: rtl/rom_read_sequencer.sv
// rom_read_sequencer: walks a 556PT5/556PT4 PROM from address 0 up to a
// programmable last address. It holds each address for a fixed access time,
// captures the chip data and hands every word downstream over a valid/ready
// handshake.
module rom_read_sequencer #(
    parameter int          DATA_WIDTH    = 8,
    parameter int          ADDRESS_WIDTH = 9,
    parameter int          ACCESS_CYCLES = 4,
    parameter logic [3:0]  READ_OP       = 4'b1100,
    parameter logic [3:0]  IDLE_OP       = 4'b0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] last_address,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    // The wait counter is 8 bits wide because ACCESS_CYCLES is limited to 1..255.
    localparam logic [7:0]               LP_WAIT_INIT = 8'(ACCESS_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LP_ADDR_ONE  = ADDRESS_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_OUTPUT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                   r_state;
    logic [7:0]               r_wait;
    logic [ADDRESS_WIDTH-1:0] r_last;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [3:0]               r_op;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic [ADDRESS_WIDTH-1:0] r_out_addr;
    logic                     r_out_valid;
    logic                     r_busy;
    logic                     r_done;

    // Sequencer FSM: every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_last      <= '0;
            r_addr      <= '0;
            r_op        <= IDLE_OP;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (r_state != S_IDLE && abort) begin
            // Abort outranks the handshake and the end-of-range check; any
            // pending word is dropped and done is never pulsed.
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_op        <= IDLE_OP;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Start is ignored while abort is also asserted.
                    if (start && !abort) begin
                        r_last  <= last_address;
                        r_addr  <= '0;
                        r_op    <= READ_OP;
                        r_busy  <= 1'b1;
                        r_wait  <= LP_WAIT_INIT;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_wait != 8'd0) begin
                        r_wait <= r_wait - 8'd1;
                    end else begin
                        r_out_data  <= data_line_in;
                        r_out_addr  <= r_addr;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        // Compare before incrementing so the top address never wraps.
                        if (r_addr == r_last) begin
                            r_done  <= 1'b1;
                            r_op    <= IDLE_OP;
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_addr + LP_ADDR_ONE;
                            r_wait  <= LP_WAIT_INIT;
                            r_state <= S_SETUP;
                        end
                    end
                end
                S_DONE: begin
                    // address_line keeps the last address after completion.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign operation    = r_op;
    assign address_line = r_addr;
    assign out_data     = r_out_data;
    assign out_addr     = r_out_addr;
    assign out_valid    = r_out_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Bench for rom_read_sequencer: a 3604-sized instance checked every cycle
// against a transaction-level model, plus a 3601-sized instance checked by
// word count, order and timing.
module tb_rom_read_sequencer;

    localparam int AC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // 3604 instance (defaults)
    logic       start, abort, ready_fix, rnd_ready, rnd_bit;
    logic [8:0] last_address;
    logic [3:0] operation;
    logic [8:0] address_line, out_addr;
    logic [7:0] data_line_in, out_data;
    logic       out_valid, out_ready, busy, done;

    // 3601 instance
    logic       start_b;
    logic [7:0] last_b;
    logic [3:0] op_b;
    logic [7:0] addr_b, out_addr_b;
    logic [3:0] data_b, out_data_b;
    logic       out_valid_b, busy_b, done_b;

    function automatic logic [7:0] chip_a(input logic [8:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction
    function automatic logic [3:0] chip_b(input logic [7:0] a);
        return a[3:0] ^ 4'h5;
    endfunction

    assign data_line_in = chip_a(address_line);
    assign data_b       = chip_b(addr_b);
    assign out_ready    = rnd_ready ? rnd_bit : ready_fix;

    always @(negedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

    rom_read_sequencer dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .last_address(last_address), .operation(operation),
        .address_line(address_line), .data_line_in(data_line_in),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    rom_read_sequencer #(.DATA_WIDTH(4), .ADDRESS_WIDTH(8), .ACCESS_CYCLES(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(1'b0),
        .last_address(last_b), .operation(op_b),
        .address_line(addr_b), .data_line_in(data_b),
        .out_data(out_data_b), .out_addr(out_addr_b), .out_valid(out_valid_b),
        .out_ready(1'b1), .busy(busy_b), .done(done_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int words_a = 0, dones_a = 0, words_b = 0, err_b = 0;
    int start_cyc, done_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake / pulse counters (values seen just before each edge).
    always @(posedge clk) begin
        if (reset_n && out_valid && out_ready) words_a <= words_a + 1;
        if (reset_n && done) dones_a <= dones_a + 1;
        if (reset_n && out_valid_b) begin
            if (out_addr_b !== 8'(words_b) || out_data_b !== chip_b(8'(words_b)))
                err_b <= err_b + 1;
            words_b <= words_b + 1;
        end
    end

    // Transaction-level model of the 3604 instance: a dump is "busy", sits
    // AC cycles on each address, then presents chip(addr) until accepted.
    logic       m_busy, m_done;
    logic [8:0] m_addr, m_last, m_oaddr;
    logic [7:0] m_data;
    int         m_age;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_done <= 0; m_addr <= 0; m_last <= 0;
            m_oaddr <= 0; m_data <= 0; m_age <= 0;
        end else if (!m_busy) begin
            if (start && !abort) begin
                m_busy <= 1; m_addr <= 0; m_age <= 0; m_last <= last_address;
            end
        end else if (abort) begin
            m_busy <= 0; m_done <= 0; m_addr <= 0;
        end else if (m_done) begin
            m_done <= 0; m_busy <= 0;
        end else if (m_age < AC) begin
            m_age <= m_age + 1;
            if (m_age == AC - 1) begin
                m_data <= chip_a(m_addr); m_oaddr <= m_addr;
            end
        end else if (out_ready) begin
            if (m_addr == m_last) m_done <= 1;
            else begin m_addr <= m_addr + 9'd1; m_age <= 0; end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("out_valid", out_valid, m_busy && !m_done && m_age == AC);
            chk("operation", operation, (m_busy && !m_done) ? 4'b1100 : 4'b0000);
            chk("address_line", address_line, m_addr);
            chk("out_data", out_data, m_data);
            chk("out_addr", out_addr, m_oaddr);
        end
    endtask

    task automatic start_a(input logic [8:0] last);
        @(negedge clk);
        start = 1; last_address = last;
        @(negedge clk);
        start_cyc = cyc;
        start = 0;
    endtask

    task automatic wait_done_a(input int lim, input bit jitter);
        bit seen;
        seen = 0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (jitter) begin
                start = 1'($urandom_range(0, 1));
                last_address = 9'($urandom);
            end
        end
        start = 0;
        done_cyc = cyc;
        chk("done_reached", seen, 1);
    endtask

    task automatic wait_word_a(input logic [8:0] a, input int lim);
        bit seen;
        seen = 0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (out_valid && out_addr == a) seen = 1;
        end
        chk("word_reached", seen, 1);
    endtask

    initial begin
        int w0, d0;
        bit seen;
        reset_n = 0; start = 0; abort = 0; last_address = 0;
        ready_fix = 1; rnd_ready = 0; start_b = 0; last_b = 0;
        fork compare_loop(); join_none
        repeat (3) @(negedge clk);
        chk("rst_op", operation, 4'b0000);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1;

        // Full 3604 dump, ready always high.
        w0 = words_a; d0 = dones_a;
        start_a(9'd511);
        wait_done_a(3000, 0);
        chk("full_cycles", done_cyc - start_cyc, 2560);
        chk("full_last_addr", address_line, 9'd511);
        @(negedge clk);
        chk("full_words", words_a - w0, 512);
        chk("full_done_pulses", dones_a - d0, 1);

        // Backpressure on word 3.
        w0 = words_a;
        start_a(9'd8);
        wait_word_a(9'd3, 50);
        ready_fix = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_addr", out_addr, 9'd3);
            chk("bp_data", out_data, 8'hA6);
            chk("bp_addrline", address_line, 9'd3);
        end
        ready_fix = 1;
        wait_done_a(200, 0);
        @(negedge clk);
        chk("bp_words", words_a - w0, 9);

        // Single word dump.
        w0 = words_a;
        start_a(9'd0);
        wait_done_a(50, 0);
        chk("single_cycles", done_cyc - start_cyc, 5);
        @(negedge clk);
        chk("single_words", words_a - w0, 1);
        chk("single_busy", busy, 0);
        chk("single_op", operation, 4'b0000);

        // Abort while presenting word 10.
        d0 = dones_a;
        start_a(9'd50);
        wait_word_a(9'd10, 200);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_op", operation, 4'b0000);
        chk("abort_addrline", address_line, 9'd0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", dones_a - d0, 0);

        // Start with abort in IDLE is ignored.
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        chk("idle_abort_start", busy, 0);

        // Restart after abort begins at address 0.
        start_a(9'd2);
        wait_word_a(9'd0, 20);
        chk("restart_addr", out_addr, 9'd0);
        wait_done_a(100, 0);

        // Randomized dumps: random ready, start/last_address wiggled while busy.
        rnd_ready = 1;
        for (int k = 0; k < 6; k++) begin
            w0 = words_a;
            start_a(9'($urandom_range(0, 30)));
            wait_done_a(2000, 1);
            @(negedge clk);
            chk("rnd_words", words_a - w0, 32'(m_last) + 1);
        end
        rnd_ready = 0;

        // Asynchronous reset between edges mid-SETUP.
        start_a(9'd20);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("arst_op", operation, 4'b0000);
        chk("arst_addrline", address_line, 9'd0);
        chk("arst_data", out_data, 8'h00);
        chk("arst_oaddr", out_addr, 9'd0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        reset_n = 1;

        // 3601 configuration.
        @(negedge clk);
        start_b = 1; last_b = 8'd255;
        @(negedge clk);
        start_cyc = cyc; start_b = 0;
        seen = 0;
        for (int i = 0; i < 700 && !seen; i++) begin
            @(negedge clk);
            if (done_b) seen = 1;
        end
        chk("b_done_reached", seen, 1);
        chk("b_cycles", cyc - start_cyc, 512);
        chk("b_last_addr", addr_b, 8'd255);
        @(negedge clk);
        chk("b_words", words_b, 256);
        chk("b_order_data", err_b, 0);
        chk("b_idle_op", op_b, 4'b0000);
        chk("b_busy", busy_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
